lif_frame_loader: RTL and testbench

- Host-side driver for the LIF/PWM neuron tile's byte-serial load port; the transmitting end of that port.
- Takes one request: a weight vector (optional) and an input vector. Emits them as byte writes on the tile's data/select/mode pins.
- Then releases the tile into run mode for a programmed number of cycles and counts the spikes it returns.
- Sits between a test/host controller (valid/ready) and the tile pins ui_in[7:0], uio_in[0], uio_in[1], uo_out[0 or 1].

---
 rtl/lif_pkg.sv | 24 ++
 rtl/lif_byte_serializer.sv | 48 ++++
 rtl/lif_frame_loader.sv | 150 +++++++++++++++
 tb/tb_lif_frame_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF tile load port: loader FSM states, byte count
// helper, no-spike marker and tile pin indices.
package lif_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_I,
        RUN,
        DONE
    } state_e;

    // Index of each control pin on the tile's uio_in bus
    localparam int SEL_W  = 0;
    localparam int MODE_N = 1;

    // Wide enough for any count width; users slice it down to CNT_BITS
    localparam logic [63:0] NO_SPIKE = '1;

    function automatic int nbytes(input int vec_bits);
        return vec_bits / 8;
    endfunction

endpackage

// File: rtl/lif_byte_serializer.sv
// Parallel-load shift register emitting a vector one byte per cycle, MSB first.
// Zeros fill from the bottom, so the byte output idles at 0 once drained.
module lif_byte_serializer
    import lif_pkg::*;
#(
    parameter int VEC_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [VEC_BITS-1:0] vec_i,
    input  logic                shift_i,
    output logic [7:0]          byte_o,
    output logic                last_o
);

    localparam int NBYTES = nbytes(VEC_BITS);
    localparam int IDX_W  = $clog2(NBYTES + 1);

    logic [VEC_BITS-1:0] sr_q, sr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (load_i) begin
            sr_d  = vec_i;
            idx_d = '0;
        end else if (shift_i) begin
            sr_d  = sr_q << 8;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    assign byte_o = sr_q[VEC_BITS-1 -: 8];
    assign last_o = (idx_q == IDX_W'(NBYTES - 1));

endmodule

// File: rtl/lif_frame_loader.sv
// Host-side driver for the LIF tile load port: shifts in weights/inputs byte by
// byte, releases the tile for a programmed run and counts returned spikes.
module lif_frame_loader
    import lif_pkg::*;
#(
    parameter int VEC_BITS = 32,
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_load_w,
    input  logic [VEC_BITS-1:0] req_weights,
    input  logic [VEC_BITS-1:0] req_inputs,
    input  logic [CNT_BITS-1:0] req_run,
    output logic [7:0]          data_out,
    output logic                sel_w,
    output logic                mode_n,
    input  logic                spike_in,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [CNT_BITS-1:0] rsp_count,
    output logic [CNT_BITS-1:0] rsp_first
);

    localparam logic [CNT_BITS-1:0] NO_SPK = NO_SPIKE[CNT_BITS-1:0];

    state_e              state_q, state_d;
    logic [VEC_BITS-1:0] inputs_q, inputs_d;
    logic [CNT_BITS-1:0] run_len_q, run_len_d;
    logic [CNT_BITS-1:0] run_idx_q, run_idx_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [CNT_BITS-1:0] first_q, first_d;
    logic                sel_w_q, sel_w_d;
    logic                mode_n_q, mode_n_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;

    logic                ser_load, ser_shift, ser_last;
    logic [VEC_BITS-1:0] ser_vec;

    lif_byte_serializer #(.VEC_BITS(VEC_BITS)) u_ser (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ser_load),
        .vec_i   (ser_vec),
        .shift_i (ser_shift),
        .byte_o  (data_out),
        .last_o  (ser_last)
    );

    always_comb begin
        state_d   = state_q;
        inputs_d  = inputs_q;
        run_len_d = run_len_q;
        run_idx_d = run_idx_q;
        count_d   = count_q;
        first_d   = first_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        ser_vec   = inputs_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    inputs_d  = req_inputs;
                    run_len_d = req_run;
                    run_idx_d = '0;
                    count_d   = '0;
                    first_d   = NO_SPK;
                    ser_load  = 1'b1;
                    ser_vec   = req_load_w ? req_weights : req_inputs;
                    state_d   = req_load_w ? LOAD_W : LOAD_I;
                end
            end
            LOAD_W: begin
                // Input vector is loaded on the last weight byte so bytes stay back-to-back
                if (ser_last) begin
                    ser_load = 1'b1;
                    state_d  = LOAD_I;
                end else begin
                    ser_shift = 1'b1;
                end
            end
            LOAD_I: begin
                ser_shift = 1'b1;
                if (ser_last) begin
                    run_idx_d = '0;
                    state_d   = (run_len_q != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (spike_in) begin
                    if (count_q != NO_SPK) count_d = count_q + CNT_BITS'(1);
                    if (count_q == '0)     first_d = run_idx_q;
                end
                if (run_idx_q == run_len_q - CNT_BITS'(1)) begin
                    state_d = DONE;
                end else begin
                    run_idx_d = run_idx_q + CNT_BITS'(1);
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Pin/handshake registers follow the next state so they line up with it
        sel_w_d     = (state_d == LOAD_W);
        mode_n_d    = !((state_d == LOAD_W) || (state_d == LOAD_I));
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            run_idx_q   <= '0;
            count_q     <= '0;
            first_q     <= NO_SPK;
            sel_w_q     <= 1'b0;
            mode_n_q    <= 1'b1;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_idx_q   <= run_idx_d;
            count_q     <= count_d;
            first_q     <= first_d;
            sel_w_q     <= sel_w_d;
            mode_n_q    <= mode_n_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        inputs_q  <= inputs_d;
        run_len_q <= run_len_d;
    end

    assign req_ready = req_ready_q;
    assign sel_w     = sel_w_q;
    assign mode_n    = mode_n_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_count = count_q;
    assign rsp_first = first_q;

endmodule

// File: tb/tb_lif_frame_loader.sv
// Bench for lif_frame_loader: directed table, randomized transactions against a
// behavioural model, mid-load reset, and a small behavioural LIF tile on the pins.
module tb_lif_frame_loader;

    localparam int VB = 32;
    localparam int CB = 8;
    localparam int NB = VB / 8;
    localparam int TH = 100;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_load_w;
    logic [VB-1:0] req_weights;
    logic [VB-1:0] req_inputs;
    logic [CB-1:0] req_run;
    logic [7:0]    data_out;
    logic          sel_w;
    logic          mode_n;
    logic          spike_in;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [CB-1:0] rsp_count;
    logic [CB-1:0] rsp_first;

    int checks = 0;
    int errors = 0;

    logic use_tile;
    logic tb_spike;

    lif_frame_loader #(.VEC_BITS(VB), .CNT_BITS(CB)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_load_w  (req_load_w),
        .req_weights (req_weights),
        .req_inputs  (req_inputs),
        .req_run     (req_run),
        .data_out    (data_out),
        .sel_w       (sel_w),
        .mode_n      (mode_n),
        .spike_in    (spike_in),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_count   (rsp_count),
        .rsp_first   (rsp_first)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural tile: shifts selected vector while mode_n=0, integrates when running
    bit [VB-1:0] tw_q = '0;
    bit [VB-1:0] ti_q = '0;
    int          mem_q = 0;
    int          lowcnt = 0;
    int          inc;
    logic        tile_spike;

    assign inc        = $countones(tw_q & ti_q);
    assign tile_spike = (mem_q + inc >= TH);
    assign spike_in   = use_tile ? tile_spike : tb_spike;

    always_ff @(posedge clk) begin
        if (!mode_n) begin
            if (sel_w) tw_q <= {tw_q[VB-9:0], data_out};
            else       ti_q <= {ti_q[VB-9:0], data_out};
            mem_q  <= 0;
            lowcnt <= lowcnt + 1;
        end else if (tile_spike) begin
            mem_q <= 0;
        end else begin
            mem_q <= mem_q + inc;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp, input int cyc);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit [7:0] vbyte(input bit [VB-1:0] v, input int k);
        return v[VB-1-8*k -: 8];
    endfunction

    // Spike accounting straight from the rules: saturating count, index of first spike
    function automatic void ref_run(input bit [7:0] run, input bit [255:0] pat,
                                    output bit [7:0] c, output bit [7:0] f);
        c = 0;
        f = 8'hFF;
        for (int r = 0; r < int'(run); r++) begin
            if (pat[r]) begin
                if (c == 0) f = 8'(r);
                if (c != 8'hFF) c = c + 8'd1;
            end
        end
    endfunction

    // Spike train a freshly loaded tile produces: integrate popcount, fire at TH, reset
    function automatic bit [255:0] tile_pat(input bit [VB-1:0] w, input bit [VB-1:0] i, input bit [7:0] run);
        bit [255:0] p;
        int m;
        int n;
        p = '0;
        m = 0;
        n = $countones(w & i);
        for (int r = 0; r < int'(run); r++) begin
            if (m + n >= TH) begin
                p[r] = 1'b1;
                m = 0;
            end else begin
                m = m + n;
            end
        end
        return p;
    endfunction

    // Called at a negedge with the loader idle; returns at a negedge, idle again
    task automatic txn(input bit lw, input bit [VB-1:0] w, input bit [VB-1:0] i,
                       input bit [7:0] run, input bit [255:0] pat, input int hold,
                       input bit [7:0] ecount, input bit [7:0] efirst);
        int L, last, r, lc0;
        bit [7:0] ed;
        bit es, em;
        logic [11:0] pins, epins;
        L    = lw ? 2 * NB : NB;
        last = L + int'(run) + 1;
        chk("req_ready_idle", req_ready, 1, 0);
        req_valid   = 1'b1;
        req_load_w  = lw;
        req_weights = w;
        req_inputs  = i;
        req_run     = run;
        lc0         = lowcnt;
        @(negedge clk);
        req_valid   = 1'b0;
        req_load_w  = 1'($urandom);
        req_weights = $urandom;
        req_inputs  = $urandom;
        req_run     = 8'($urandom);
        for (int j = 1; j <= last; j++) begin
            r = j - L - 1;
            tb_spike = (r >= 0 && r < int'(run)) ? pat[r] : 1'($urandom);
            if (j <= L) begin
                em = 1'b0;
                if (lw && j <= NB) begin
                    es = 1'b1;
                    ed = vbyte(w, j - 1);
                end else begin
                    es = 1'b0;
                    ed = vbyte(i, lw ? j - 1 - NB : j - 1);
                end
            end else begin
                em = 1'b1;
                es = 1'b0;
                ed = 8'h00;
            end
            pins  = {req_ready, rsp_valid, mode_n, sel_w, data_out};
            epins = {1'b0, (j == last), em, es, ed};
            chk("pins{rdy,vld,mode_n,sel_w,data}", 64'(pins), 64'(epins), j);
            if (j < last) @(negedge clk);
        end
        chk("rsp_count", rsp_count, ecount, last);
        chk("rsp_first", rsp_first, efirst, last);
        chk("mode_n_low_cycles", 64'(lowcnt - lc0), 64'(L), last);
        if (lw) chk("tile_weights", tw_q, w, last);
        chk("tile_inputs", ti_q, i, last);
        for (int h = 1; h <= hold; h++) begin
            tb_spike = 1'($urandom);
            @(negedge clk);
            pins = {req_ready, rsp_valid, mode_n, sel_w, data_out};
            chk("hold_pins", 64'(pins), 64'(12'h600), last + h);
            chk("hold_result", {rsp_count, rsp_first}, {ecount, efirst}, last + h);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("release{rsp_valid,req_ready}", {rsp_valid, req_ready}, 2'b01, last + hold + 1);
    endtask

    typedef struct {
        bit          lw;
        bit [VB-1:0] w;
        bit [VB-1:0] i;
        bit [7:0]    run;
        bit [255:0]  pat;
        int          hold;
        bit [7:0]    ecount;
        bit [7:0]    efirst;
    } vec_t;

    vec_t tbl[5];

    initial begin
        bit [7:0]   ec, ef;
        bit [255:0] p;
        bit [VB-1:0] rw, ri;
        bit [7:0]   rr;
        bit         rl;

        tbl[0] = '{1'b1, 32'hDEADBEEF, 32'h0000FFFF, 8'd4,   256'h0,   10, 8'd0,   8'hFF};
        tbl[1] = '{1'b0, 32'h0,        32'h01020304, 8'd8,   256'h24,  0,  8'd2,   8'd2};
        tbl[2] = '{1'b1, 32'hA5A55A5A, 32'h12345678, 8'd0,   '1,       0,  8'd0,   8'hFF};
        tbl[3] = '{1'b0, 32'h0,        32'hCAFEF00D, 8'd255, '1,       0,  8'hFF,  8'd0};
        tbl[4] = '{1'b1, 32'h80000001, 32'h00000080, 8'd3,   256'h5,   2,  8'd2,   8'd0};

        use_tile    = 1'b0;
        tb_spike    = 1'b0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_load_w  = 1'b0;
        req_weights = '0;
        req_inputs  = '0;
        req_run     = '0;
        rsp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {req_ready, data_out, sel_w, mode_n, rsp_valid, rsp_count, rsp_first},
            {1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {req_ready, data_out, sel_w, mode_n, rsp_valid, rsp_count, rsp_first},
            {1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF}, 0);

        for (int t = 0; t < 5; t++)
            txn(tbl[t].lw, tbl[t].w, tbl[t].i, tbl[t].run, tbl[t].pat, tbl[t].hold,
                tbl[t].ecount, tbl[t].efirst);

        // Reset while the third weight byte is on the pins
        req_valid   = 1'b1;
        req_load_w  = 1'b1;
        req_weights = 32'h11223344;
        req_inputs  = 32'h55667788;
        req_run     = 8'd5;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_load_byte2", {sel_w, mode_n, data_out}, {1'b1, 1'b0, 8'h33}, 3);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_load", {req_ready, data_out, sel_w, mode_n, rsp_valid, rsp_count, rsp_first},
            {1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF}, 4);
        reset = 1'b0;
        txn(1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0, 8'd6, 256'h22, 0, 8'd2, 8'd1);

        // Randomized transactions against the reference model
        for (int t = 0; t < 20; t++) begin
            rl = 1'($urandom);
            rw = $urandom;
            ri = $urandom;
            rr = 8'($urandom_range(0, 24));
            p  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ref_run(rr, p, ec, ef);
            txn(rl, rw, ri, rr, p, int'($urandom_range(0, 3)), ec, ef);
        end

        // End-to-end with the tile's spike output driving spike_in
        use_tile = 1'b1;
        p = tile_pat('1, '1, 8'd16);
        ref_run(8'd16, p, ec, ef);
        txn(1'b1, '1, '1, 8'd16, p, 0, ec, ef);
        rw = $urandom | 32'hF0F0F0F0;
        p = tile_pat(rw, '1, 8'd40);
        ref_run(8'd40, p, ec, ef);
        txn(1'b1, rw, '1, 8'd40, p, 1, ec, ef);
        use_tile = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
